pc_gen: RTL and testbench

Parametrised program-counter generator for the single-cycle CPU, successor to the original branch/jump next-PC unit. Holds the architectural PC and computes the next PC for sequential, branch, jump, jump-register, trap and exception-return flows. Adds a return-address stack (RAS) and an exception PC (EPC) register. Sits between the control unit/ALU compare result and the instruction memory address port.

---
 rtl/pc_gen.sv | 174 +++++++++++++++++
 tb/tb_pc_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the single-cycle CPU.
// Holds the architectural PC and selects the next PC for sequential, branch,
// jump, jump-register, trap and exception-return flows. It includes a circular
// return-address stack (RAS) and an exception PC (EPC) register.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   pc_en      PC write enable (0 = stall)
//   branch     taken conditional branch
//   jump       absolute jump (j/jal)
//   jr         register-indirect jump
//   call       link qualifier for jump/jr (pushes return address)
//   ret        return qualifier for jr (pops RAS)
//   trap       exception request
//   eret       exception return
//   imm32      sign-extended branch byte offset
//   imm26      jump index
//   jr_target  register operand for jr
//   PC         current PC
//   NPC        combinational next PC
//   epc        saved exception PC
//   ras_count  valid RAS entries
//   misalign   last accepted jr target was misaligned (registered)
module pc_gen #(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  RESET_VEC = '0,
   parameter logic [31:0]       TRAP_VEC  = 32'h0000_0180,
   parameter int unsigned       RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pc_en,
   input  logic                         branch,
   input  logic                         jump,
   input  logic                         jr,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         trap,
   input  logic                         eret,
   input  logic [WIDTH-1:0]             imm32,
   input  logic [25:0]                  imm26,
   input  logic [WIDTH-1:0]             jr_target,
   output logic [WIDTH-1:0]             PC,
   output logic [WIDTH-1:0]             NPC,
   output logic [WIDTH-1:0]             epc,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         misalign
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [WIDTH-1:0] TrapVec = WIDTH'(TRAP_VEC);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic             mis_q, mis_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    top_q, top_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];

   logic [WIDTH-1:0] seq;
   logic             jr_misaligned;
   logic             ras_nonempty;
   logic             sel_itrap;
   logic             take_trap;
   logic             ras_act;
   logic             do_ret;
   logic             do_push;
   logic             do_repl;
   logic             do_pop;
   logic             ras_we;
   logic [PW-1:0]    ras_widx;

   assign seq           = pc_q + WIDTH'(4);
   assign jr_misaligned = (jr_target[1:0] != 2'b00);
   assign ras_nonempty  = (cnt_q != '0);

   // A misaligned jr only traps when nothing of higher priority claims the cycle.
   assign sel_itrap = !trap && !eret && !branch && jr && jr_misaligned;
   assign take_trap = trap || sel_itrap;

   // Next-PC selection, highest priority first.
   always_comb begin
      NPC = seq;
      if (trap) begin
         NPC = TrapVec;
      end else if (eret) begin
         NPC = epc_q;
      end else if (branch) begin
         NPC = seq + imm32;
      end else if (sel_itrap) begin
         NPC = TrapVec;
      end else if (jr && ret && ras_nonempty) begin
         NPC = ras_q[top_q];
      end else if (jr) begin
         NPC = jr_target;
      end else if (jump) begin
         NPC = {pc_q[WIDTH-1:28], imm26, 2'b00};
      end
   end

   // RAS acts only on accepted cycles whose selection is jump or a clean jr.
   assign ras_act = pc_en && !trap && !eret && !branch && !sel_itrap && (jr || jump);
   assign do_ret  = ras_act && jr && ret;
   // call+ret on an empty stack degrades to a plain push.
   assign do_push = ras_act && call && !(do_ret && ras_nonempty);
   assign do_repl = ras_act && call && do_ret && ras_nonempty;
   assign do_pop  = do_ret && !call && ras_nonempty;

   assign ras_we   = (do_push || do_repl) && !reset;
   assign ras_widx = do_push ? top_q + PW'(1) : top_q;

   always_comb begin
      pc_d  = pc_q;
      epc_d = epc_q;
      mis_d = mis_q;
      cnt_d = cnt_q;
      top_d = top_q;

      if (take_trap) begin
         pc_d  = TrapVec;
         epc_d = pc_q;
      end else if (pc_en) begin
         pc_d = NPC;
      end

      if (sel_itrap) begin
         mis_d = 1'b1;
      end else if (pc_en || trap) begin
         mis_d = 1'b0;
      end

      if (do_push) begin
         top_d = top_q + PW'(1);
         // Full stack: the push overwrites the oldest entry, count saturates.
         if (cnt_q != CW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (do_pop) begin
         top_d = top_q - PW'(1);
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VEC;
         epc_q <= '0;
         mis_q <= 1'b0;
         cnt_q <= '0;
         top_q <= '0;
      end else begin
         pc_q  <= pc_d;
         epc_q <= epc_d;
         mis_q <= mis_d;
         cnt_q <= cnt_d;
         top_q <= top_d;
      end
   end

   // Stack storage is not reset; entries are unobservable until pushed.
   always_ff @(posedge clk) begin
      if (ras_we) begin
         ras_q[ras_widx] <= seq;
      end
   end

   assign PC        = pc_q;
   assign epc       = epc_q;
   assign ras_count = cnt_q;
   assign misalign  = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pc_gen;

   logic        clk;
   logic        reset;
   logic        pc_en, branch, jump, jr, call, ret, trap, eret;
   logic [31:0] imm32, jr_target;
   logic [25:0] imm26;
   logic [31:0] PC, NPC, epc;
   logic [2:0]  ras_count;
   logic        misalign;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_pc, m_epc;
   logic        m_mis;
   logic [31:0] m_ras [$];

   pc_gen #(
      .WIDTH     (32),
      .RESET_VEC (32'h0),
      .TRAP_VEC  (32'h0000_0180),
      .RAS_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pc_en     (pc_en),
      .branch    (branch),
      .jump      (jump),
      .jr        (jr),
      .call      (call),
      .ret       (ret),
      .trap      (trap),
      .eret      (eret),
      .imm32     (imm32),
      .imm26     (imm26),
      .jr_target (jr_target),
      .PC        (PC),
      .NPC       (NPC),
      .epc       (epc),
      .ras_count (ras_count),
      .misalign  (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_npc();
      logic [31:0] s;
      s = m_pc + 32'd4;
      if (trap) return 32'h180;
      if (eret) return m_epc;
      if (branch) return s + imm32;
      if (jr && jr_target[1:0] != 2'b00) return 32'h180;
      if (jr && ret && m_ras.size() > 0) return m_ras[m_ras.size()-1];
      if (jr) return jr_target;
      if (jump) return {m_pc[31:28], imm26, 2'b00};
      return s;
   endfunction

   task automatic model_step();
      logic [31:0] n, s;
      logic        itrap, rt;
      n     = ref_npc();
      s     = m_pc + 32'd4;
      itrap = !trap && !eret && !branch && jr && (jr_target[1:0] != 2'b00);
      if (reset) begin
         m_pc  = 32'h0;
         m_epc = 32'h0;
         m_mis = 1'b0;
         m_ras.delete();
      end else if (trap || itrap) begin
         m_epc = m_pc;
         m_pc  = 32'h180;
         m_mis = itrap;
      end else if (pc_en) begin
         if (!eret && !branch && (jr || jump)) begin
            rt = jr && ret;
            if (call && rt && m_ras.size() > 0) begin
               m_ras[m_ras.size()-1] = s;
            end else if (call) begin
               m_ras.push_back(s);
               if (m_ras.size() > 4) void'(m_ras.pop_front());
            end else if (rt && m_ras.size() > 0) begin
               void'(m_ras.pop_back());
            end
         end
         m_pc  = n;
         m_mis = 1'b0;
      end
   endtask

   task automatic set_in(input logic r, input logic en, input logic br, input logic jp,
                         input logic j_r, input logic cl, input logic rt, input logic tp,
                         input logic er, input logic [31:0] imm, input logic [25:0] i26,
                         input logic [31:0] jt);
      reset = r; pc_en = en; branch = br; jump = jp; jr = j_r; call = cl; ret = rt;
      trap = tp; eret = er; imm32 = imm; imm26 = i26; jr_target = jt;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (PC !== 32'h0) begin
         failures++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0);
      end
      checks++;
      if (epc !== 32'h0 || ras_count !== 3'd0 || misalign !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got epc=%h cnt=%0d mis=%b exp 0/0/0", epc, ras_count, misalign);
      end
      checks++;
      if (NPC !== 32'h4) begin
         failures++; $display("FAIL reset_npc got=%h exp=%h", NPC, 32'h4);
      end
   endtask

   task automatic test_seq();
      for (int i = 1; i <= 4; i++) begin
         set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         tick();
         checks++;
         if (PC !== 32'(4 * i)) begin
            failures++; $display("FAIL seq_pc got=%h exp=%h", PC, 32'(4 * i));
         end
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (PC !== 32'd16) begin
         failures++; $display("FAIL stall_pc got=%h exp=%h", PC, 32'd16);
      end
   endtask

   task automatic test_branch_jump();
      set_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h100);
      tick();
      set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 0, 0);
      tick();
      checks++;
      if (PC !== 32'hFC) begin
         failures++; $display("FAIL branch_pc got=%h exp=%h", PC, 32'hFC);
      end
      set_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h3000_0010);
      tick();
      set_in(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 26'h40, 0);
      tick();
      checks++;
      if (PC !== 32'h3000_0100) begin
         failures++; $display("FAIL jump_pc got=%h exp=%h", PC, 32'h3000_0100);
      end
   endtask

   task automatic test_ras();
      logic [31:0] exp_pop [4];
      exp_pop = '{32'h54, 32'h44, 32'h34, 32'h24};
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 1; i <= 5; i++) begin
         set_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'(16 * i));
         tick();
         set_in(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 26'h400, 0);
         tick();
      end
      checks++;
      if (ras_count !== 3'd4) begin
         failures++; $display("FAIL ras_full_count got=%0d exp=4", ras_count);
      end
      for (int i = 0; i < 4; i++) begin
         set_in(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h800);
         tick();
         checks++;
         if (PC !== exp_pop[i]) begin
            failures++; $display("FAIL ras_pop got=%h exp=%h", PC, exp_pop[i]);
         end
      end
      set_in(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h800);
      tick();
      checks++;
      if (PC !== 32'h800 || ras_count !== 3'd0) begin
         failures++;
         $display("FAIL ras_empty_pop got pc=%h cnt=%0d exp pc=800 cnt=0", PC, ras_count);
      end
   endtask

   task automatic test_trap();
      set_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h200);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tick();
      checks++;
      if (PC !== 32'h180 || epc !== 32'h200) begin
         failures++; $display("FAIL trap got pc=%h epc=%h exp pc=180 epc=200", PC, epc);
      end
      set_in(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      checks++;
      if (PC !== 32'h200) begin
         failures++; $display("FAIL eret_pc got=%h exp=%h", PC, 32'h200);
      end
      set_in(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tick();
      set_in(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tick();
      checks++;
      if (PC !== 32'h180 || epc !== 32'h180) begin
         failures++; $display("FAIL trap_eret got pc=%h epc=%h exp pc=180 epc=180", PC, epc);
      end
   endtask

   task automatic test_misalign();
      set_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h40);
      tick();
      set_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h1002);
      tick();
      checks++;
      if (PC !== 32'h180 || epc !== 32'h40 || misalign !== 1'b1) begin
         failures++;
         $display("FAIL misalign_trap got pc=%h epc=%h mis=%b exp 180/40/1", PC, epc, misalign);
      end
      set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (misalign !== 1'b0 || PC !== 32'h184) begin
         failures++;
         $display("FAIL misalign_clear got mis=%b pc=%h exp 0/184", misalign, PC);
      end
   endtask

   task automatic test_reset_mid();
      set_in(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 26'h10, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tick();
      set_in(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 26'h10, 0);
      tick();
      checks++;
      if (PC !== 32'h0 || ras_count !== 3'd0 || epc !== 32'h0 || misalign !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got pc=%h cnt=%0d epc=%h mis=%b exp all 0",
                  PC, ras_count, epc, misalign);
      end
   endtask

   task automatic test_random();
      logic [31:0] jt;
      logic [31:0] exp_npc;
      for (int i = 0; i < 400; i++) begin
         jt = $urandom;
         if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
         set_in($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 11) == 0, $urandom, 26'($urandom), jt);
         #1;
         exp_npc = ref_npc();
         if (!reset) begin
            checks++;
            if (NPC !== exp_npc) begin
               failures++; $display("FAIL rand_npc got=%h exp=%h", NPC, exp_npc);
            end
         end
         tick();
         checks++;
         if (PC !== m_pc || epc !== m_epc || ras_count !== 3'(m_ras.size()) ||
             misalign !== m_mis) begin
            failures++;
            $display("FAIL rand_state got pc=%h epc=%h cnt=%0d mis=%b exp pc=%h epc=%h cnt=%0d mis=%b",
                     PC, epc, ras_count, misalign, m_pc, m_epc, m_ras.size(), m_mis);
         end
      end
   endtask

   initial begin
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_mis = 1'b0;
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      test_reset();
      test_seq();
      test_branch_jump();
      test_ras();
      test_trap();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
